// File: rtl/miriscv_writeback_stage.sv
// Writeback stage: load alignment/extension, GPR write-source select, memory
// response tracking (stall, hold-while-stalled, drain of killed responses), instret.
module miriscv_writeback_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned GPR_ADDR_W   = 5,
  parameter int unsigned WB_SRC_W     = 2,
  parameter int unsigned MEM_ACCESS_W = 3,
  parameter int unsigned INSTRET_W    = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cu_kill_w_i,
  input  logic                    cu_stall_w_i,
  output logic                    w_stall_req_o,
  input  logic                    m_valid_i,
  input  logic                    m_gpr_wr_en_i,
  input  logic [GPR_ADDR_W-1:0]   m_gpr_wr_addr_i,
  input  logic [WB_SRC_W-1:0]     m_gpr_src_sel_i,
  input  logic [XLEN-1:0]         m_alu_result_i,
  input  logic [XLEN-1:0]         m_mdu_result_i,
  input  logic                    m_mem_req_i,
  input  logic [MEM_ACCESS_W-1:0] m_mem_size_i,
  input  logic [1:0]              m_mem_addr_i,
  input  logic                    data_rvalid_i,
  input  logic [XLEN-1:0]         data_rdata_i,
  output logic                    w_gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0]   w_gpr_wr_addr_o,
  output logic [XLEN-1:0]         w_gpr_wr_data_o,
  output logic                    w_retire_o,
  output logic [INSTRET_W-1:0]    w_instret_o
);

  localparam logic [WB_SRC_W-1:0] WB_SRC_ALU = WB_SRC_W'(0);
  localparam logic [WB_SRC_W-1:0] WB_SRC_MDU = WB_SRC_W'(1);
  localparam logic [WB_SRC_W-1:0] WB_SRC_LSU = WB_SRC_W'(2);

  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = MEM_ACCESS_W'(0);
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = MEM_ACCESS_W'(1);
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = MEM_ACCESS_W'(2);
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = MEM_ACCESS_W'(4);
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = MEM_ACCESS_W'(5);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic [XLEN-1:0]        rdata_buf;
  logic [INSTRET_W-1:0]   instret;

  logic                   mem_op;
  logic                   resp_ok;
  logic                   resp_use;
  logic                   done;
  logic                   retire;
  logic [XLEN-1:0]        rdata_sel;
  logic [XLEN-1:0]        rdata_rot;
  logic [XLEN-1:0]        load_data;
  logic [XLEN-1:0]        wr_data;

  always_comb begin
    mem_op    = m_valid_i & m_mem_req_i;
    resp_ok   = ((state == S_IDLE) & data_rvalid_i) | (state == S_HOLD);
    resp_use  = (state != S_DRAIN) & resp_ok;
    done      = m_valid_i & (~m_mem_req_i | resp_use);
    retire    = done & ~cu_kill_w_i & ~cu_stall_w_i;
    rdata_sel = (state == S_HOLD) ? rdata_buf : data_rdata_i;
  end

  // Byte lanes are brought down to bit 0 by rotating right by the byte offset.
  always_comb begin
    rdata_rot = rdata_sel;
    case (m_mem_addr_i)
      2'd1:    rdata_rot = {rdata_sel[7:0],  rdata_sel[XLEN-1:8]};
      2'd2:    rdata_rot = {rdata_sel[15:0], rdata_sel[XLEN-1:16]};
      2'd3:    rdata_rot = {rdata_sel[23:0], rdata_sel[XLEN-1:24]};
      default: rdata_rot = rdata_sel;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (m_mem_size_i)
      MEM_ACCESS_BYTE:  load_data = {{(XLEN-8){rdata_rot[7]}}, rdata_rot[7:0]};
      MEM_ACCESS_UBYTE: load_data = {{(XLEN-8){1'b0}}, rdata_rot[7:0]};
      MEM_ACCESS_HALF:  load_data = {{(XLEN-16){rdata_rot[15]}}, rdata_rot[15:0]};
      MEM_ACCESS_UHALF: load_data = {{(XLEN-16){1'b0}}, rdata_rot[15:0]};
      MEM_ACCESS_WORD:  load_data = rdata_rot;
      default:          load_data = '0;
    endcase
  end

  always_comb begin
    wr_data = '0;
    case (m_gpr_src_sel_i)
      WB_SRC_ALU: wr_data = m_alu_result_i;
      WB_SRC_MDU: wr_data = m_mdu_result_i;
      WB_SRC_LSU: wr_data = load_data;
      default:    wr_data = '0;
    endcase
  end

  // All outputs are forced low while reset is asserted.
  always_comb begin
    w_stall_req_o   = ~rst_i & mem_op & ~resp_use;
    w_retire_o      = ~rst_i & retire;
    w_gpr_wr_en_o   = ~rst_i & retire & m_gpr_wr_en_i & (m_gpr_wr_addr_i != '0);
    w_gpr_wr_addr_o = rst_i ? '0 : m_gpr_wr_addr_i;
    w_gpr_wr_data_o = rst_i ? '0 : wr_data;
    w_instret_o     = rst_i ? '0 : instret;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      rdata_buf <= '0;
      instret   <= '0;
    end else begin
      if (retire) instret <= instret + INSTRET_W'(1);
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            if (cu_kill_w_i & ~data_rvalid_i) begin
              state <= S_DRAIN;
            end else if (data_rvalid_i & ~cu_kill_w_i & cu_stall_w_i) begin
              state     <= S_HOLD;
              rdata_buf <= data_rdata_i;
            end
          end
        end
        S_HOLD: begin
          if (cu_kill_w_i | ~cu_stall_w_i) state <= S_IDLE;
        end
        S_DRAIN: begin
          if (data_rvalid_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_writeback_stage.sv
// Directed bench for miriscv_writeback_stage; instret narrowed to 4 bits to reach wrap.
module tb_miriscv_writeback_stage;

  localparam logic [1:0] SRC_ALU = 2'd0, SRC_MDU = 2'd1, SRC_LSU = 2'd2, SRC_BAD = 2'd3;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4, SZ_HU = 3'd5;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cu_kill_w_i, cu_stall_w_i;
  logic        w_stall_req_o;
  logic        m_valid_i, m_gpr_wr_en_i;
  logic [4:0]  m_gpr_wr_addr_i;
  logic [1:0]  m_gpr_src_sel_i;
  logic [31:0] m_alu_result_i, m_mdu_result_i;
  logic        m_mem_req_i;
  logic [2:0]  m_mem_size_i;
  logic [1:0]  m_mem_addr_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        w_gpr_wr_en_o;
  logic [4:0]  w_gpr_wr_addr_o;
  logic [31:0] w_gpr_wr_data_o;
  logic        w_retire_o;
  logic [3:0]  w_instret_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  miriscv_writeback_stage #(
    .XLEN(32), .GPR_ADDR_W(5), .WB_SRC_W(2), .MEM_ACCESS_W(3), .INSTRET_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cu_kill_w_i(cu_kill_w_i), .cu_stall_w_i(cu_stall_w_i),
    .w_stall_req_o(w_stall_req_o),
    .m_valid_i(m_valid_i), .m_gpr_wr_en_i(m_gpr_wr_en_i),
    .m_gpr_wr_addr_i(m_gpr_wr_addr_i), .m_gpr_src_sel_i(m_gpr_src_sel_i),
    .m_alu_result_i(m_alu_result_i), .m_mdu_result_i(m_mdu_result_i),
    .m_mem_req_i(m_mem_req_i), .m_mem_size_i(m_mem_size_i), .m_mem_addr_i(m_mem_addr_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .w_gpr_wr_en_o(w_gpr_wr_en_o), .w_gpr_wr_addr_o(w_gpr_wr_addr_o),
    .w_gpr_wr_data_o(w_gpr_wr_data_o), .w_retire_o(w_retire_o), .w_instret_o(w_instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    cu_kill_w_i = 0; cu_stall_w_i = 0; m_valid_i = 0; m_gpr_wr_en_i = 0;
    m_gpr_wr_addr_i = '0; m_gpr_src_sel_i = SRC_ALU; m_alu_result_i = '0;
    m_mdu_result_i = '0; m_mem_req_i = 0; m_mem_size_i = SZ_W; m_mem_addr_i = '0;
    data_rvalid_i = 0; data_rdata_i = '0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    clear();
    m_valid_i = 1; m_gpr_wr_en_i = 1; m_gpr_wr_addr_i = rd;
    m_gpr_src_sel_i = SRC_ALU; m_alu_result_i = val;
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [2:0] sz, input logic [1:0] off);
    clear();
    m_valid_i = 1; m_gpr_wr_en_i = 1; m_gpr_wr_addr_i = rd; m_gpr_src_sel_i = SRC_LSU;
    m_mem_req_i = 1; m_mem_size_i = sz; m_mem_addr_i = off;
  endtask

  initial begin
    // Reset with an instruction present: outputs must stay low.
    clear(); rst_i = 1; alu_op(5'd7, 32'h55);
    #1;
    chk("rst_wr_en",  64'(w_gpr_wr_en_o), 64'd0);
    chk("rst_retire", 64'(w_retire_o), 64'd0);
    chk("rst_addr",   64'(w_gpr_wr_addr_o), 64'd0);
    chk("rst_data",   64'(w_gpr_wr_data_o), 64'd0);
    tick(); rst_i = 0; clear(); #1;
    chk("rst_instret", 64'(w_instret_o), 64'd0);
    chk("rst_stall",   64'(w_stall_req_o), 64'd0);

    // 1. ADD x5
    tick(); alu_op(5'd5, 32'h1234); #1;
    chk("t1_wr_en",  64'(w_gpr_wr_en_o), 64'd1);
    chk("t1_addr",   64'(w_gpr_wr_addr_o), 64'd5);
    chk("t1_data",   64'(w_gpr_wr_data_o), 64'h1234);
    chk("t1_retire", 64'(w_retire_o), 64'd1);
    chk("t1_stall",  64'(w_stall_req_o), 64'd0);
    tick(); clear(); #1;
    chk("t1_instret", 64'(w_instret_o), 64'd1);

    // 2. LB offset 3, two-cycle late response
    tick(); load_op(5'd7, SZ_B, 2'd3); #1;
    chk("t2_stall0", 64'(w_stall_req_o), 64'd1);
    chk("t2_wr0",    64'(w_gpr_wr_en_o), 64'd0);
    chk("t2_ret0",   64'(w_retire_o), 64'd0);
    tick(); #1;
    chk("t2_stall1", 64'(w_stall_req_o), 64'd1);
    tick(); data_rvalid_i = 1; data_rdata_i = 32'h80FF_0000; #1;
    chk("t2_stall2", 64'(w_stall_req_o), 64'd0);
    chk("t2_wr",     64'(w_gpr_wr_en_o), 64'd1);
    chk("t2_data",   64'(w_gpr_wr_data_o), 64'hFFFF_FF80);
    tick(); clear(); #1;
    chk("t2_instret", 64'(w_instret_o), 64'd2);

    // 3. LHU offset 2, response arrives while stalled -> HOLD
    tick(); load_op(5'd8, SZ_HU, 2'd2); cu_stall_w_i = 1;
    data_rvalid_i = 1; data_rdata_i = 32'hBEEF_0000; #1;
    chk("t3_ret_st",  64'(w_retire_o), 64'd0);
    chk("t3_wr_st",   64'(w_gpr_wr_en_o), 64'd0);
    chk("t3_stallrq", 64'(w_stall_req_o), 64'd0);
    tick(); cu_stall_w_i = 0; data_rvalid_i = 0; data_rdata_i = 32'h0; #1;
    chk("t3_wr",   64'(w_gpr_wr_en_o), 64'd1);
    chk("t3_data", 64'(w_gpr_wr_data_o), 64'h0000_BEEF);
    chk("t3_ret",  64'(w_retire_o), 64'd1);
    tick(); clear(); #1;
    chk("t3_instret", 64'(w_instret_o), 64'd3);

    // 4. Killed load -> DRAIN; next LW ignores first response
    tick(); load_op(5'd9, SZ_W, 2'd0); cu_kill_w_i = 1; #1;
    chk("t4_kill_ret", 64'(w_retire_o), 64'd0);
    tick(); load_op(5'd9, SZ_W, 2'd0); #1;
    chk("t4_stall_a", 64'(w_stall_req_o), 64'd1);
    tick(); data_rvalid_i = 1; data_rdata_i = 32'h0000_DEAD; #1;
    chk("t4_drain_stall", 64'(w_stall_req_o), 64'd1);
    chk("t4_drain_wr",    64'(w_gpr_wr_en_o), 64'd0);
    tick(); data_rvalid_i = 1; data_rdata_i = 32'h0000_1111; #1;
    chk("t4_wr",    64'(w_gpr_wr_en_o), 64'd1);
    chk("t4_data",  64'(w_gpr_wr_data_o), 64'h1111);
    chk("t4_stall", 64'(w_stall_req_o), 64'd0);
    tick(); clear(); #1;
    chk("t4_instret", 64'(w_instret_o), 64'd4);

    // 5. Write to x0, store, MDU, bad source
    tick(); alu_op(5'd0, 32'hFFFF); #1;
    chk("t5_x0_wr",  64'(w_gpr_wr_en_o), 64'd0);
    chk("t5_x0_ret", 64'(w_retire_o), 64'd1);
    tick(); clear(); m_valid_i = 1; m_mem_req_i = 1; m_mem_size_i = SZ_B;
    data_rvalid_i = 1; data_rdata_i = 32'hCAFE_CAFE; #1;
    chk("t5_sb_ret", 64'(w_retire_o), 64'd1);
    chk("t5_sb_wr",  64'(w_gpr_wr_en_o), 64'd0);
    tick(); alu_op(5'd3, 32'h1); m_gpr_src_sel_i = SRC_MDU; m_mdu_result_i = 32'hABCD; #1;
    chk("t5_mdu", 64'(w_gpr_wr_data_o), 64'hABCD);
    tick(); alu_op(5'd4, 32'h77); m_gpr_src_sel_i = SRC_BAD; #1;
    chk("t5_bad_data", 64'(w_gpr_wr_data_o), 64'd0);
    chk("t5_bad_wr",   64'(w_gpr_wr_en_o), 64'd1);
    tick(); clear(); data_rvalid_i = 1; data_rdata_i = 32'h1234_5678; #1;
    chk("stray_wr",  64'(w_gpr_wr_en_o), 64'd0);
    chk("stray_ret", 64'(w_retire_o), 64'd0);
    tick(); clear(); #1;
    chk("t5_instret", 64'(w_instret_o), 64'd8);

    // LW offset 1 after stray response: still waits for its own response
    tick(); load_op(5'd10, SZ_W, 2'd1); #1;
    chk("rot_stall", 64'(w_stall_req_o), 64'd1);
    tick(); data_rvalid_i = 1; data_rdata_i = 32'h4433_2211; #1;
    chk("rot_data", 64'(w_gpr_wr_data_o), 64'h1144_3322);
    tick(); load_op(5'd11, SZ_H, 2'd0); data_rvalid_i = 1; data_rdata_i = 32'h0000_8001; #1;
    chk("lh_data", 64'(w_gpr_wr_data_o), 64'hFFFF_8001);
    tick(); load_op(5'd12, SZ_BU, 2'd1); data_rvalid_i = 1; data_rdata_i = 32'h0000_9A00; #1;
    chk("lbu_data", 64'(w_gpr_wr_data_o), 64'h0000_009A);
    tick(); load_op(5'd12, SZ_W, 2'd0); cu_kill_w_i = 1; data_rvalid_i = 1; #1;
    chk("killrv_wr", 64'(w_gpr_wr_en_o), 64'd0);
    tick(); load_op(5'd13, SZ_W, 2'd0); data_rvalid_i = 1; data_rdata_i = 32'h600D; #1;
    chk("killrv_idle_wr", 64'(w_gpr_wr_en_o), 64'd1);
    tick(); clear(); #1;
    chk("pre_wrap_instret", 64'(w_instret_o), 64'd12);

    // 6. Wrap of the 4-bit counter
    for (int i = 0; i < 3; i++) begin
      tick(); alu_op(5'd1, 32'(i));
    end
    tick(); clear(); #1;
    chk("instret_max", 64'(w_instret_o), 64'hF);
    tick(); alu_op(5'd1, 32'h0); tick(); clear(); #1;
    chk("instret_wrap0", 64'(w_instret_o), 64'd0);
    tick(); alu_op(5'd1, 32'h0); tick(); clear(); #1;
    chk("instret_wrap1", 64'(w_instret_o), 64'd1);

    // Reset while in HOLD
    tick(); load_op(5'd14, SZ_W, 2'd0); cu_stall_w_i = 1;
    data_rvalid_i = 1; data_rdata_i = 32'h7777_7777;
    tick(); data_rvalid_i = 0; cu_stall_w_i = 0; rst_i = 1; #1;
    chk("hrst_wr",     64'(w_gpr_wr_en_o), 64'd0);
    chk("hrst_ret",    64'(w_retire_o), 64'd0);
    chk("hrst_data",   64'(w_gpr_wr_data_o), 64'd0);
    chk("hrst_instret", 64'(w_instret_o), 64'd0);
    tick(); rst_i = 0; clear(); data_rvalid_i = 1; data_rdata_i = 32'h9999; #1;
    chk("hrst_stray_wr", 64'(w_gpr_wr_en_o), 64'd0);
    tick(); load_op(5'd15, SZ_W, 2'd0); #1;
    chk("hrst_idle_stall", 64'(w_stall_req_o), 64'd1);
    tick(); data_rvalid_i = 1; data_rdata_i = 32'h2468; #1;
    chk("hrst_load_data", 64'(w_gpr_wr_data_o), 64'h2468);
    tick(); clear(); #1;
    chk("hrst_instret1", 64'(w_instret_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
